// File: rtl/mux_stage_sched.sv
// Multi-pass sequencer for the BRAM/URAM read mux feeding the vector units.
// Launches one mux-sequencer pass per stage, counts returned beats, and
// inserts a drain gap between passes so the addx/C1 pipeline can flush.
module mux_stage_sched #(
  parameter int                   BEAT_W       = 13,
  parameter int                   DRAIN_CYCLES = 4,
  parameter int                   TIMEOUT_W    = 16,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT      = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [3:0]        i_cmd_n_start,
  input  logic [4:0]        i_cmd_num_stages,
  input  logic [15:0]       i_cmd_mode_mask,
  input  logic [BEAT_W-1:0] i_cmd_beats,
  input  logic              i_abort,
  output logic              o_seq_en,
  output logic              o_seq_start,
  output logic              o_seq_mode,
  output logic [3:0]        o_seq_n,
  input  logic              i_seq_valid,
  output logic [3:0]        o_stage,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [3:0]           n_start_q, n_start_d;
  logic [4:0]           num_stages_q, num_stages_d;
  logic [15:0]          mode_mask_q, mode_mask_d;
  logic [BEAT_W-1:0]    beats_q, beats_d;
  logic [3:0]           stage_q, stage_d;
  logic [BEAT_W-1:0]    beat_q, beat_d;
  logic [TIMEOUT_W-1:0] wd_q, wd_d;
  logic [DRAIN_W-1:0]   drain_q, drain_d;
  logic                 err_q, err_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic                 busy_q, busy_d;
  logic                 seq_en_q, seq_en_d;
  logic                 seq_start_q, seq_start_d;
  logic                 seq_mode_q, seq_mode_d;
  logic [3:0]           seq_n_q, seq_n_d;
  logic                 done_q, done_d;

  logic                 accept;
  logic                 beat_hit;
  logic                 wd_hit;
  logic                 drain_end;
  logic                 last_stage;
  logic [3:0]           n_src;
  logic [15:0]          mask_src;

  assign accept     = (state_q == S_IDLE) && i_cmd_valid;
  assign beat_hit   = (state_q == S_RUN) && i_seq_valid && ((beat_q + BEAT_W'(1)) == beats_q);
  assign wd_hit     = (state_q == S_RUN) && ((wd_q + TIMEOUT_W'(1)) == TIMEOUT);
  assign drain_end  = (state_q == S_DRAIN) && (drain_q == DRAIN_W'(DRAIN_CYCLES - 1));
  assign last_stage = ({1'b0, stage_q} == (num_stages_q - 5'd1));
  assign n_src      = accept ? i_cmd_n_start   : n_start_q;
  assign mask_src   = accept ? i_cmd_mode_mask : mode_mask_q;

  // State register; reset parks the FSM in IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; abort outranks completion, completion outranks timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (i_cmd_valid) state_d = (i_cmd_num_stages == 5'd0) ? S_DONE : S_LAUNCH;
      S_LAUNCH: state_d = i_abort ? S_DONE : S_RUN;
      S_RUN: begin
        if (i_abort)       state_d = S_DONE;
        else if (beat_hit) state_d = S_DRAIN;
        else if (wd_hit)   state_d = S_DONE;
      end
      S_DRAIN: begin
        if (i_abort)        state_d = S_DONE;
        else if (drain_end) state_d = last_stage ? S_DONE : S_LAUNCH;
      end
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Command capture, pass index, beat/watchdog/drain counters and sticky error
  always_comb begin
    n_start_d    = n_start_q;
    num_stages_d = num_stages_q;
    mode_mask_d  = mode_mask_q;
    beats_d      = beats_q;
    stage_d      = stage_q;
    beat_d       = beat_q;
    wd_d         = wd_q;
    drain_d      = drain_q;
    err_d        = err_q;
    case (state_q)
      S_IDLE: begin
        if (i_cmd_valid) begin
          n_start_d    = i_cmd_n_start;
          num_stages_d = i_cmd_num_stages;
          mode_mask_d  = i_cmd_mode_mask;
          beats_d      = i_cmd_beats;
          stage_d      = 4'd0;
          err_d        = 1'b0;
        end
      end
      S_LAUNCH: begin
        beat_d = '0;
        wd_d   = '0;
      end
      S_RUN: begin
        wd_d    = wd_q + TIMEOUT_W'(1);
        drain_d = '0;
        if (i_seq_valid) beat_d = beat_q + BEAT_W'(1);
        if (wd_hit && !beat_hit && !i_abort) err_d = 1'b1;
      end
      S_DRAIN: begin
        drain_d = drain_q + DRAIN_W'(1);
        if (drain_end && !last_stage && !i_abort) stage_d = stage_q + 4'd1;
      end
      default: ;
    endcase
  end

  // Registered outputs decoded from the upcoming state; mode/n latch on LAUNCH entry
  always_comb begin
    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    seq_en_d    = (state_d == S_LAUNCH) || (state_d == S_RUN) || (state_d == S_DRAIN);
    seq_start_d = (state_d == S_LAUNCH);
    done_d      = (state_d == S_DONE);
    seq_mode_d  = seq_mode_q;
    seq_n_d     = seq_n_q;
    if (state_d == S_LAUNCH) begin
      seq_mode_d = mask_src[stage_d];
      seq_n_d    = n_src + stage_d;
    end
  end

  // Datapath and output flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_start_q    <= '0;
      num_stages_q <= '0;
      mode_mask_q  <= '0;
      beats_q      <= '0;
      stage_q      <= '0;
      beat_q       <= '0;
      wd_q         <= '0;
      drain_q      <= '0;
      err_q        <= 1'b0;
      cmd_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      seq_en_q     <= 1'b0;
      seq_start_q  <= 1'b0;
      seq_mode_q   <= 1'b0;
      seq_n_q      <= '0;
      done_q       <= 1'b0;
    end else begin
      n_start_q    <= n_start_d;
      num_stages_q <= num_stages_d;
      mode_mask_q  <= mode_mask_d;
      beats_q      <= beats_d;
      stage_q      <= stage_d;
      beat_q       <= beat_d;
      wd_q         <= wd_d;
      drain_q      <= drain_d;
      err_q        <= err_d;
      cmd_ready_q  <= cmd_ready_d;
      busy_q       <= busy_d;
      seq_en_q     <= seq_en_d;
      seq_start_q  <= seq_start_d;
      seq_mode_q   <= seq_mode_d;
      seq_n_q      <= seq_n_d;
      done_q       <= done_d;
    end
  end

  assign o_cmd_ready = cmd_ready_q;
  assign o_busy      = busy_q;
  assign o_seq_en    = seq_en_q;
  assign o_seq_start = seq_start_q;
  assign o_seq_mode  = seq_mode_q;
  assign o_seq_n     = seq_n_q;
  assign o_done      = done_q;
  assign o_err       = err_q;
  assign o_stage     = stage_q;

endmodule
